// File: rtl/pea_token_writer_if.sv
// Host-side bundle for pea_token_writer: command/operand handshakes, FIFO
// free-space inputs and the registered FIFO write ports.
interface pea_token_writer_if #(
  parameter int word_size   = 16,
  parameter int buffer_size = 1024
);
  localparam int FS_W = (buffer_size > 1) ? $clog2(buffer_size) : 1;

  logic                 cmd_valid;
  logic [7:0]           cmd_instr;
  logic [2:0]           cmd_arg1;
  logic [4:0]           cmd_arg2;
  logic                 cmd_ready;
  logic                 data_valid;
  logic [word_size-1:0] data_in;
  logic                 data_ready;
  logic [FS_W-1:0]      control_free_space;
  logic [FS_W-1:0]      data_free_space;
  logic                 control_wr_en;
  logic [word_size-1:0] control_out;
  logic                 data_wr_en;
  logic [word_size-1:0] data_out;
  logic                 busy;
  logic [5:0]           tokens_remaining;

  modport master (
    output cmd_valid, cmd_instr, cmd_arg1, cmd_arg2, data_valid, data_in,
           control_free_space, data_free_space,
    input  cmd_ready, data_ready, control_wr_en, control_out, data_wr_en,
           data_out, busy, tokens_remaining
  );

  modport slave (
    input  cmd_valid, cmd_instr, cmd_arg1, cmd_arg2, data_valid, data_in,
           control_free_space, data_free_space,
    output cmd_ready, data_ready, control_wr_en, control_out, data_wr_en,
           data_out, busy, tokens_remaining
  );
endinterface

// File: rtl/pea_token_writer.sv
// Writes one command token, then its operand tokens, into the PEA control/data
// FIFOs; a command is only taken once data-FIFO room for all its operands exists.
module pea_token_writer #(
  parameter int word_size   = 16,
  parameter int buffer_size = 1024
) (
  input  logic               clk,
  input  logic               rst,
  pea_token_writer_if.slave  host_if
);
  localparam int FS_W  = (buffer_size > 1) ? $clog2(buffer_size) : 1;
  localparam int CMP_W = (FS_W > 6) ? FS_W : 6;

  typedef enum logic {IDLE, DATA} state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic                 r_control_wr_en;
  logic [word_size-1:0] r_control_out;
  logic                 r_data_wr_en;
  logic [word_size-1:0] r_data_out;
  logic [5:0]           r_tokens;

  logic [5:0]           w_need;
  logic [CMP_W-1:0]     w_need_ext;
  logic [CMP_W-1:0]     w_dfs_ext;
  logic                 w_room_ok;
  logic                 w_cmd_ready;
  logic                 w_data_ready;
  logic                 w_cmd_accept;
  logic                 w_data_accept;

  // Operand count owed by the presented command, decoded from opcode bits [1:0].
  always_comb begin
    w_need = 6'd0;
    unique case (host_if.cmd_instr[1:0])
      2'b00:   w_need = {1'b0, host_if.cmd_arg2} + 6'd1;
      2'b01:   w_need = 6'd1;
      2'b10:   w_need = {1'b0, host_if.cmd_arg2};
      default: w_need = 6'd0;
    endcase
  end

  assign w_need_ext = CMP_W'(w_need);
  assign w_dfs_ext  = CMP_W'(host_if.data_free_space);
  assign w_room_ok  = (host_if.control_free_space != '0) && (w_dfs_ext >= w_need_ext);

  // Pending write strobes mean the free-space counts have not caught up yet.
  always_comb begin
    w_next_state = r_state;
    w_cmd_ready  = 1'b0;
    w_data_ready = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_cmd_ready = w_room_ok && !r_control_wr_en && !r_data_wr_en;
        if (host_if.cmd_valid && w_cmd_ready && (w_need != 6'd0))
          w_next_state = DATA;
      end
      DATA: begin
        w_data_ready = 1'b1;
        if (host_if.data_valid && (r_tokens == 6'd1))
          w_next_state = IDLE;
      end
    endcase
  end

  assign w_cmd_accept  = host_if.cmd_valid && w_cmd_ready;
  assign w_data_accept = host_if.data_valid && w_data_ready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_control_wr_en <= 1'b0;
      r_control_out   <= '0;
      r_data_wr_en    <= 1'b0;
      r_data_out      <= '0;
      r_tokens        <= 6'd0;
    end else begin
      r_control_wr_en <= w_cmd_accept;
      r_data_wr_en    <= w_data_accept;
      if (w_cmd_accept) begin
        r_control_out <= word_size'({host_if.cmd_instr, host_if.cmd_arg1, host_if.cmd_arg2});
        r_tokens      <= w_need;
      end else if (w_data_accept) begin
        r_data_out <= host_if.data_in;
        r_tokens   <= r_tokens - 6'd1;
      end
    end
  end

  assign host_if.cmd_ready        = w_cmd_ready;
  assign host_if.data_ready       = w_data_ready;
  assign host_if.control_wr_en    = r_control_wr_en;
  assign host_if.control_out      = r_control_out;
  assign host_if.data_wr_en       = r_data_wr_en;
  assign host_if.data_out         = r_data_out;
  assign host_if.busy             = (r_state != IDLE);
  assign host_if.tokens_remaining = r_tokens;
endmodule

// File: tb/tb_pea_token_writer.sv
// Directed plus random stimulus for pea_token_writer, checked each cycle against
// a transaction-level model of owed operands and pending FIFO writes.
module tb_pea_token_writer;
  logic clk = 1'b0;
  logic rst = 1'b1;

  pea_token_writer_if #(.word_size(16), .buffer_size(1024)) bus ();

  pea_token_writer #(.word_size(16), .buffer_size(1024)) dut (
    .clk     (clk),
    .rst     (rst),
    .host_if (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          owed = 0;
  bit          expCtrlPulse = 1'b0;
  bit          expDataPulse = 1'b0;
  logic [15:0] expCtrlOut = 16'h0;
  logic [15:0] expDataOut = 16'h0;

  function automatic int reqCount(input logic [7:0] instr, input logic [4:0] arg2);
    case (instr[1:0])
      2'b00:   return int'(arg2) + 1;
      2'b01:   return 1;
      2'b10:   return int'(arg2);
      default: return 0;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check the DUT against the model with the current inputs,
  // advance the model by the spec's acceptance rules, then cross the clock edge.
  task automatic applyStimulus();
    int  need;
    bit  expCmdReady;
    bit  expDataReady;
    bit  cmdAcc;
    bit  dataAcc;
    #1;
    need         = reqCount(bus.cmd_instr, bus.cmd_arg2);
    expCmdReady  = (owed == 0) && (int'(bus.control_free_space) >= 1) &&
                   (int'(bus.data_free_space) >= need) && !expCtrlPulse && !expDataPulse;
    expDataReady = (owed != 0);
    checkOutput("control_wr_en", 32'(bus.control_wr_en), 32'(expCtrlPulse));
    checkOutput("control_out", 32'(bus.control_out), 32'(expCtrlOut));
    checkOutput("data_wr_en", 32'(bus.data_wr_en), 32'(expDataPulse));
    checkOutput("data_out", 32'(bus.data_out), 32'(expDataOut));
    checkOutput("busy", 32'(bus.busy), 32'(owed != 0));
    checkOutput("tokens_remaining", 32'(bus.tokens_remaining), 32'(owed));
    checkOutput("cmd_ready", 32'(bus.cmd_ready), 32'(expCmdReady));
    checkOutput("data_ready", 32'(bus.data_ready), 32'(expDataReady));
    cmdAcc       = bus.cmd_valid && expCmdReady;
    dataAcc      = bus.data_valid && expDataReady;
    expCtrlPulse = cmdAcc;
    expDataPulse = dataAcc;
    if (cmdAcc) begin
      expCtrlOut = {bus.cmd_instr, bus.cmd_arg1, bus.cmd_arg2};
      owed       = need;
    end
    if (dataAcc) begin
      expDataOut = bus.data_in;
      owed       = owed - 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    rst            = 1'b1;
    bus.cmd_valid  = 1'b0;
    bus.data_valid = 1'b0;
    @(posedge clk);
    #1;
    rst          = 1'b0;
    owed         = 0;
    expCtrlPulse = 1'b0;
    expDataPulse = 1'b0;
    expCtrlOut   = 16'h0;
    expDataOut   = 16'h0;
  endtask

  task automatic setCommand(input logic valid, input logic [7:0] instr,
                            input logic [2:0] arg1, input logic [4:0] arg2);
    bus.cmd_valid = valid;
    bus.cmd_instr = instr;
    bus.cmd_arg1  = arg1;
    bus.cmd_arg2  = arg2;
  endtask

  task automatic feedOperands(input int count);
    for (int i = 0; i < count; i++) begin
      bus.data_valid = 1'b1;
      bus.data_in    = 16'($urandom);
      applyStimulus();
    end
    bus.data_valid = 1'b0;
  endtask

  initial begin
    setCommand(1'b0, 8'h00, 3'd0, 5'd0);
    bus.data_valid         = 1'b0;
    bus.data_in            = 16'h0;
    bus.control_free_space = 10'd512;
    bus.data_free_space    = 10'd512;
    @(posedge clk);
    #1;
    applyReset();

    // STP degree 2 with operands 5, -3, 7 back to back, then an immediate EVP
    setCommand(1'b1, 8'b1010_1000, 3'b101, 5'd2);
    applyStimulus();
    setCommand(1'b0, 8'h00, 3'd0, 5'd0);
    bus.data_valid = 1'b1;
    bus.data_in = 16'd5;      applyStimulus();
    bus.data_in = 16'hFFFD;   applyStimulus();
    bus.data_in = 16'd7;      applyStimulus();
    bus.data_valid = 1'b0;
    setCommand(1'b1, 8'h01, 3'd2, 5'd9);
    applyStimulus();
    applyStimulus();
    setCommand(1'b0, 8'h00, 3'd0, 5'd0);
    feedOperands(1);
    applyStimulus();

    // EVB of 4 blocked by 3 free data words, released at 4
    bus.data_free_space = 10'd3;
    setCommand(1'b1, 8'h02, 3'd1, 5'd4);
    repeat (3) applyStimulus();
    bus.data_free_space = 10'd4;
    applyStimulus();
    setCommand(1'b0, 8'h00, 3'd0, 5'd0);
    feedOperands(4);
    applyStimulus();
    applyStimulus();
    bus.data_free_space = 10'd512;

    // zero-operand commands: EVB length 0, then RST, each held for re-accept
    setCommand(1'b1, 8'h02, 3'd3, 5'd0);
    repeat (3) applyStimulus();
    setCommand(1'b1, 8'hFF, 3'd7, 5'd31);
    repeat (3) applyStimulus();
    setCommand(1'b0, 8'h00, 3'd0, 5'd0);
    applyStimulus();

    // largest STP: 32 operands need exactly 32 free words
    bus.data_free_space = 10'd31;
    setCommand(1'b1, 8'h04, 3'd0, 5'd31);
    repeat (3) applyStimulus();
    bus.data_free_space = 10'd32;
    applyStimulus();
    setCommand(1'b0, 8'h00, 3'd0, 5'd0);
    feedOperands(32);
    applyStimulus();
    bus.data_free_space = 10'd512;

    // reset in the middle of an EVB operand stream
    setCommand(1'b1, 8'h02, 3'd4, 5'd4);
    applyStimulus();
    setCommand(1'b0, 8'h00, 3'd0, 5'd0);
    feedOperands(2);
    applyReset();
    bus.data_valid = 1'b1;
    bus.data_in    = 16'h1234;
    applyStimulus();
    bus.data_valid = 1'b0;
    setCommand(1'b1, 8'h01, 3'd6, 5'd0);
    applyStimulus();
    setCommand(1'b0, 8'h00, 3'd0, 5'd0);
    feedOperands(1);
    applyStimulus();

    // full control FIFO, and stray operands while idle
    bus.control_free_space = 10'd0;
    setCommand(1'b1, 8'h03, 3'd0, 5'd0);
    bus.data_valid = 1'b1;
    bus.data_in    = 16'hBEEF;
    repeat (3) applyStimulus();
    setCommand(1'b0, 8'h00, 3'd0, 5'd0);
    bus.data_valid = 1'b0;
    bus.control_free_space = 10'd512;
    applyStimulus();

    // random traffic, including tight free-space conditions
    for (int i = 0; i < 400; i++) begin
      bus.control_free_space = 10'($urandom_range(0, 3));
      bus.data_free_space    = 10'($urandom_range(0, 40));
      setCommand(1'($urandom_range(0, 1)), 8'($urandom), 3'($urandom), 5'($urandom));
      bus.data_valid = ($urandom_range(0, 3) != 0);
      bus.data_in    = 16'($urandom);
      applyStimulus();
    end
    setCommand(1'b0, 8'h00, 3'd0, 5'd0);
    bus.data_valid = 1'b0;
    applyStimulus();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
